// File: rtl/spice_node_integrator_pkg.sv
// Shared definitions for the node-voltage integrator: voltage width and
// rails, engine state encodings, and the adder-tree width helper.
package spice_node_integrator_pkg;

  localparam int SNI_W = 10;

  localparam logic signed [SNI_W-1:0] SNI_HI = {1'b0, {(SNI_W-1){1'b1}}};
  localparam logic signed [SNI_W-1:0] SNI_LO = {1'b1, {(SNI_W-1){1'b0}}};

  localparam logic [1:0] SNI_IDLE = 2'd0;
  localparam logic [1:0] SNI_RUN  = 2'd1;
  localparam logic [1:0] SNI_DONE = 2'd2;

  // Width that holds the sum of n_in sign-extended data_w slots with no overflow
  function automatic int sni_sum_w(input int data_w, input int n_in);
    return data_w + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/spice_node_integrator_if.sv
// Current/voltage bundle between the branch models (master) and the node
// integrator (slave): packed branch currents, init/start controls, node
// voltage, digital level and burst status.
interface spice_node_integrator_if import spice_node_integrator_pkg::*; #(
  parameter int N_IN   = 4,
  parameter int DATA_W = SNI_W
);

  logic [N_IN*DATA_W-1:0]   i_bus;
  logic                     init_load;
  logic signed [DATA_W-1:0] init_val;
  logic                     start;
  logic signed [DATA_W-1:0] v;
  logic                     p;
  logic                     busy;
  logic                     done;
  logic                     settled;
  logic                     timeout;

  modport master (
    output i_bus, init_load, init_val, start,
    input  v, p, busy, done, settled, timeout
  );

  modport slave (
    input  i_bus, init_load, init_val, start,
    output v, p, busy, done, settled, timeout
  );

endinterface

// File: rtl/spice_current_adder.sv
// Combinational sign-extending adder over N_IN packed signed current slots.
// The output is wide enough that the sum can never overflow.
module spice_current_adder import spice_node_integrator_pkg::*; #(
  parameter int N_IN   = 4,
  parameter int DATA_W = SNI_W,
  parameter int SUM_W  = sni_sum_w(DATA_W, N_IN)
) (
  input  logic [N_IN*DATA_W-1:0] i_bus,
  output logic signed [SUM_W-1:0] sum
);

  // Accumulate every slot, each sign-extended to the full sum width
  always_comb begin
    sum = '0;
    for (int k = 0; k < N_IN; k++) begin
      sum = sum + SUM_W'($signed(i_bus[k*DATA_W +: DATA_W]));
    end
  end

endmodule

// File: rtl/spice_node_integrator.sv
// Node-voltage state element: integrates the summed branch currents into
// v in bounded relaxation bursts. A burst ends when the node has been
// quiet for SETTLE_CNT consecutive steps or after MAX_STEPS steps.
module spice_node_integrator import spice_node_integrator_pkg::*; #(
  parameter int N_IN       = 4,
  parameter int DATA_W     = SNI_W,
  parameter int SHIFT      = 2,
  parameter int SETTLE_THR = 1,
  parameter int SETTLE_CNT = 4,
  parameter int MAX_STEPS  = 64,
  parameter logic signed [DATA_W-1:0] INIT = SNI_LO
) (
  input logic                   eclk,
  input logic                   ereset_n,
  spice_node_integrator_if.slave bus
);

  localparam int SUM_W = sni_sum_w(DATA_W, N_IN);
  localparam int RAW_W = SUM_W + 1;
  localparam int QW    = $clog2(SETTLE_CNT + 1);
  localparam int SW    = $clog2(MAX_STEPS + 1);

  localparam logic signed [DATA_W-1:0] V_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] V_LO = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [QW-1:0]     QUIET_DONE = QW'(SETTLE_CNT);
  localparam logic [SW-1:0]     STEP_LIMIT = SW'(MAX_STEPS);
  localparam logic [DATA_W:0]   DV_THR     = (DATA_W+1)'(SETTLE_THR);

  logic [1:0]               state;
  logic signed [DATA_W-1:0] v_q;
  logic [QW-1:0]            quiet_cnt;
  logic [SW-1:0]            step_cnt;
  logic                     settled_q;
  logic                     timeout_q;

  logic signed [SUM_W-1:0]  sum_p0;
  logic signed [SUM_W-1:0]  sum_sh_p0;
  logic signed [RAW_W-1:0]  raw_p0;
  logic signed [DATA_W-1:0] v_nxt_p0;
  logic signed [DATA_W:0]   dv_p0;
  logic [DATA_W:0]          dv_mag_p0;
  logic                     quiet_p0;
  logic [QW-1:0]            quiet_nxt;
  logic [SW-1:0]            step_nxt;
  logic                     exit_settle;
  logic                     exit_timeout;

  // Clamp a widened voltage onto the representable rails
  function automatic logic signed [DATA_W-1:0] sat_v(input logic signed [RAW_W-1:0] x);
    if (x > RAW_W'(V_HI)) return V_HI;
    if (x < RAW_W'(V_LO)) return V_LO;
    return x[DATA_W-1:0];
  endfunction

  // Magnitude of a step; the step never reaches the most negative code
  function automatic logic [DATA_W:0] mag_dv(input logic signed [DATA_W:0] d);
    return d[DATA_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  spice_current_adder #(
    .N_IN   (N_IN),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_adder (
    .i_bus (bus.i_bus),
    .sum   (sum_p0)
  );

  // Integration step: scale the current, integrate, clamp, measure the step
  always_comb begin
    sum_sh_p0 = sum_p0 >>> SHIFT;
    raw_p0    = RAW_W'(v_q) + RAW_W'(sum_sh_p0);
    v_nxt_p0  = sat_v(raw_p0);
    dv_p0     = (DATA_W+1)'(v_nxt_p0) - (DATA_W+1)'(v_q);
    dv_mag_p0 = mag_dv(dv_p0);
    quiet_p0  = (dv_mag_p0 <= DV_THR);
  end

  // Post-update counter values and burst exit decision (settle beats timeout)
  always_comb begin
    if (!quiet_p0)                      quiet_nxt = '0;
    else if (quiet_cnt == QUIET_DONE)   quiet_nxt = quiet_cnt;
    else                                quiet_nxt = quiet_cnt + 1'b1;
    step_nxt     = step_cnt + 1'b1;
    exit_settle  = (quiet_nxt == QUIET_DONE);
    exit_timeout = !exit_settle && (step_nxt == STEP_LIMIT);
  end

  // Engine FSM, node voltage, counters and burst result flags
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state     <= SNI_IDLE;
      v_q       <= INIT;
      quiet_cnt <= '0;
      step_cnt  <= '0;
      settled_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        SNI_RUN: begin
          v_q       <= v_nxt_p0;
          quiet_cnt <= quiet_nxt;
          step_cnt  <= step_nxt;
          if (exit_settle) begin
            state     <= SNI_DONE;
            settled_q <= 1'b1;
          end else if (exit_timeout) begin
            state     <= SNI_DONE;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE: v may be preloaded, and a start launches a burst
          // from the freshly loaded value when both arrive together.
          if (bus.init_load) v_q <= bus.init_val;
          if (bus.start) begin
            state     <= SNI_RUN;
            quiet_cnt <= '0;
            step_cnt  <= '0;
            settled_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.v       = v_q;
  assign bus.p       = ~v_q[DATA_W-1];
  assign bus.busy    = (state == SNI_RUN);
  assign bus.done    = (state == SNI_DONE);
  assign bus.settled = settled_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_spice_node_integrator.sv
// Scoreboard bench for spice_node_integrator with N_IN=2, SHIFT=2,
// SETTLE_THR=1, SETTLE_CNT=4, MAX_STEPS=64 and a 10-bit node voltage.
module tb_spice_node_integrator;

  localparam int NI   = 2;
  localparam int DW   = 10;
  localparam int SH   = 2;
  localparam int THR  = 1;
  localparam int SCNT = 4;
  localparam int MAXS = 64;
  localparam int VHI  = 511;
  localparam int VLO  = -512;

  logic eclk = 1'b0;
  logic ereset_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_v_q[$];
  int exp_len_q[$];
  int exp_set_q[$];
  int exp_to_q[$];
  int cur_v;

  bit prev_busy;
  bit prev_done;
  int mon_steps;

  spice_node_integrator_if #(.N_IN(NI), .DATA_W(DW)) sbus();

  spice_node_integrator #(
    .N_IN       (NI),
    .DATA_W     (DW),
    .SHIFT      (SH),
    .SETTLE_THR (THR),
    .SETTLE_CNT (SCNT),
    .MAX_STEPS  (MAXS)
  ) dut (
    .eclk     (eclk),
    .ereset_n (ereset_n),
    .bus      (sbus)
  );

  always #5 eclk = ~eclk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // floor(s / 2**SH) using plain integer division
  function automatic int floor_div(input int s);
    int d;
    d = 1 << SH;
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  // Reference: whole burst from cur_v with constant currents a, b
  task automatic model_burst(input int a, input int b);
    int v, q, n, vn, dv;
    bit fin;
    v = cur_v; q = 0; n = 0; fin = 0;
    while (!fin) begin
      n++;
      vn = v + floor_div(a + b);
      if (vn > VHI) vn = VHI;
      if (vn < VLO) vn = VLO;
      dv = vn - v;
      if (dv < 0) dv = -dv;
      q = (dv <= THR) ? q + 1 : 0;
      v = vn;
      exp_v_q.push_back(v);
      if (q >= SCNT) begin
        exp_set_q.push_back(1); exp_to_q.push_back(0); fin = 1;
      end else if (n >= MAXS) begin
        exp_set_q.push_back(0); exp_to_q.push_back(1); fin = 1;
      end
    end
    exp_len_q.push_back(n);
    cur_v = v;
  endtask

  task automatic set_slots(input int a, input int b);
    logic [DW-1:0] sa, sb;
    sa = a[DW-1:0];
    sb = b[DW-1:0];
    sbus.i_bus = {sb, sa};
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < MAXS + 10; i++) begin
      @(posedge eclk); #1;
      if (sbus.done) begin ok = 1; break; end
    end
    check({name, "_done_seen"}, int'(ok), 1);
  endtask

  task automatic run_burst(input string name, input bit load, input int lval,
                           input int a, input int b, input int disturb_at);
    set_slots(a, b);
    sbus.init_load = load;
    sbus.init_val  = lval[DW-1:0];
    sbus.start     = 1'b1;
    if (load) cur_v = lval;
    model_burst(a, b);
    @(posedge eclk); #1;
    sbus.start = 1'b0;
    sbus.init_load = 1'b0;
    check({name, "_busy_next"}, int'(sbus.busy), 1);
    check({name, "_flags_clr"}, int'({sbus.done, sbus.settled, sbus.timeout}), 0);
    if (disturb_at > 0) begin
      repeat (disturb_at) begin @(posedge eclk); #1; end
      if (sbus.busy) begin
        sbus.init_load = 1'b1;
        sbus.init_val  = DW'($urandom);
        sbus.start     = 1'b1;
        @(posedge eclk); #1;
        sbus.init_load = 1'b0;
        sbus.start     = 1'b0;
      end
    end
    wait_done(name);
    check({name, "_final_v"}, sbus.v, cur_v);
    check({name, "_busy_end"}, int'(sbus.busy), 0);
  endtask

  // Monitor: compare each completed step and each burst result against the queues
  always @(negedge eclk) begin
    int e;
    if (!ereset_n) begin
      prev_busy = 0; prev_done = 0; mon_steps = 0;
    end else begin
      if (prev_busy) begin
        mon_steps++;
        if (exp_v_q.size() == 0) check("sb_step_unexpected", 1, 0);
        else begin
          e = exp_v_q.pop_front();
          check("step_v", sbus.v, e);
          check("step_p", int'(sbus.p), (e >= 0) ? 1 : 0);
        end
      end
      if (sbus.done && !prev_done) begin
        if (exp_len_q.size() == 0) check("sb_done_unexpected", 1, 0);
        else begin
          check("burst_len", mon_steps, exp_len_q.pop_front());
          check("burst_settled", int'(sbus.settled), exp_set_q.pop_front());
          check("burst_timeout", int'(sbus.timeout), exp_to_q.pop_front());
        end
        mon_steps = 0;
      end
      prev_busy = sbus.busy;
      prev_done = sbus.done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, lv, dis;
    bit ld;
    sbus.i_bus = '0; sbus.init_load = 1'b0; sbus.init_val = '0; sbus.start = 1'b0;
    cur_v = VLO;
    #12;
    check("rst_v", sbus.v, VLO);
    check("rst_p", int'(sbus.p), 0);
    check("rst_busy", int'(sbus.busy), 0);
    check("rst_done", int'(sbus.done), 0);
    check("rst_flags", int'({sbus.settled, sbus.timeout}), 0);
    @(posedge eclk); #1;
    ereset_n = 1'b1;
    repeat (3) @(posedge eclk); #1;
    check("idle_v", sbus.v, VLO);
    check("idle_busy_done", int'({sbus.busy, sbus.done}), 0);

    run_burst("ramp", 1, 0, 64, 64, 0);
    check("ramp_clamp_v", sbus.v, VHI);
    check("ramp_settled", int'(sbus.settled), 1);

    run_burst("hold", 1, 100, 64, -64, 0);
    check("hold_v", sbus.v, 100);
    check("hold_settled", int'(sbus.settled), 1);

    run_burst("drift", 1, 0, 8, 0, 0);
    check("drift_v", sbus.v, 128);
    check("drift_timeout", int'(sbus.timeout), 1);
    check("drift_settled", int'(sbus.settled), 0);

    sbus.init_load = 1'b1; sbus.init_val = -10'sd77;
    @(posedge eclk); #1;
    sbus.init_load = 1'b0;
    cur_v = -77;
    check("load_done_v", sbus.v, -77);
    check("load_done_hold", int'(sbus.done), 1);

    set_slots(8, 0);
    sbus.init_load = 1'b1; sbus.init_val = '0; sbus.start = 1'b1;
    cur_v = 0;
    model_burst(8, 0);
    @(posedge eclk); #1;
    sbus.init_load = 1'b0; sbus.start = 1'b0;
    repeat (9) @(posedge eclk);
    #3;
    check("midrst_busy_before", int'(sbus.busy), 1);
    ereset_n = 1'b0;
    #1;
    check("midrst_v", sbus.v, VLO);
    check("midrst_busy", int'(sbus.busy), 0);
    check("midrst_done", int'(sbus.done), 0);
    check("midrst_p", int'(sbus.p), 0);
    exp_v_q.delete(); exp_len_q.delete(); exp_set_q.delete(); exp_to_q.delete();
    cur_v = VLO;
    @(posedge eclk); #1;
    ereset_n = 1'b1;
    @(posedge eclk); #1;
    check("postrst_idle", int'({sbus.busy, sbus.done}), 0);

    run_burst("rerun", 1, -300, 20, 10, 0);
    run_burst("disturb", 1, 0, 8, 0, 5);
    run_burst("restart", 0, 0, 3, 1, 0);

    for (int i = 0; i < 20; i++) begin
      ld  = 1'($urandom_range(0, 1));
      lv  = int'($urandom_range(0, 1023)) - 512;
      a   = int'($urandom_range(0, 80)) - 40;
      b   = int'($urandom_range(0, 80)) - 40;
      if ($urandom_range(0, 5) == 0) begin a = 0; b = 0; end
      dis = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_burst("rand", ld, lv, a, b, dis);
    end

    repeat (2) @(posedge eclk); #1;
    check("sb_drain", exp_v_q.size() + exp_len_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
